// File: rtl/phase_bus_sequencer.sv
// Phase-bus access engine: runs one masked multi-board WRITE, READ or ADC transaction
// per accepted command, timing each setup/strobe/release phase in clock cycles.
module phase_bus_sequencer #(
   parameter int         NUM_BOARDS      = 4,
   parameter int         WAIT_CYCLES     = 21,
   parameter int         ADC_CONV_CYCLES = 64,
   parameter logic [2:0] PORT_MUX        = 3'b011,
   parameter logic [2:0] PORT_ADC_HIGH   = 3'b100,
   parameter logic [2:0] PORT_ADC_LOW    = 3'b101
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [2:0]               cmd_port,
   input  logic [NUM_BOARDS-1:0]    cmd_board_mask,
   input  logic [8*NUM_BOARDS-1:0]  cmd_wdata,
   input  logic [7:0]               cmd_mux,
   output logic                     busy,
   output logic                     done,
   output logic                     rsp_err,
   output logic [7:0]               rsp_count,
   output logic [16*NUM_BOARDS-1:0] rsp_data,
   output logic [NUM_BOARDS-1:0]    BOARD_X,
   output logic [2:0]               AddessPortPin,
   output logic                     RdP,
   output logic                     WrP,
   output logic [7:0]               Data_Out_Port,
   input  logic [7:0]               Data_In_Port,
   output logic                     data_dir
);

   localparam int IW      = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;
   localparam int MAX_CYC = (WAIT_CYCLES > ADC_CONV_CYCLES) ? WAIT_CYCLES : ADC_CONV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] W_LAST = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] C_LAST = CW'(ADC_CONV_CYCLES - 1);

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_ADC   = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_STROBE   = 3'd2;
   localparam logic [2:0] S_RELEASE  = 3'd3;
   localparam logic [2:0] S_NEXT     = 3'd4;
   localparam logic [2:0] S_ADC_WAIT = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   localparam logic [1:0] K_BCAST = 2'd0;
   localparam logic [1:0] K_LOW   = 2'd1;
   localparam logic [1:0] K_BOARD = 2'd2;

   logic [2:0]               r_state;
   logic [CW-1:0]            r_cnt;
   logic [1:0]               r_op;
   logic [2:0]               r_port;
   logic [NUM_BOARDS-1:0]    r_mask;
   logic [8*NUM_BOARDS-1:0]  r_wdata;
   logic [7:0]               r_mux;
   logic [NUM_BOARDS-1:0]    r_pending;
   logic [IW-1:0]            r_cur;
   logic [1:0]               r_bcast_left;
   logic                     r_wait_pend;
   logic                     r_adc_lo;
   logic [NUM_BOARDS-1:0]    r_sel;
   logic [2:0]               r_addr;
   logic [7:0]               r_dout;
   logic                     r_dir;
   logic                     r_rd;
   logic                     r_rsp_err;
   logic [7:0]               r_rsp_count;
   logic [16*NUM_BOARDS-1:0] r_rsp_data;

   logic                     w_found;
   logic [IW-1:0]            w_low;
   logic                     w_have_next;
   logic [1:0]               w_nkind;
   logic [NUM_BOARDS-1:0]    w_nsel;
   logic [2:0]               w_naddr;
   logic [7:0]               w_ndout;
   logic                     w_ndir;
   logic                     w_nrd;
   logic                     w_phase_end;
   logic                     w_start;
   logic                     w_to_wait;
   logic                     w_to_done;
   logic [IW:0]              w_byte;
   logic                     w_on_bus;

   // Next access to launch: pending broadcasts first, then the ADC low read, then the lowest board.
   always_comb begin
      // NOTE: every always_comb output gets a default up front so no path can infer a latch.
      w_found     = 1'b0;
      w_low       = '0;
      w_have_next = 1'b1;
      w_nkind     = K_BOARD;
      w_nsel      = '0;
      w_naddr     = r_port;
      w_ndout     = 8'h00;
      w_ndir      = 1'b0;
      w_nrd       = 1'b1;
      for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_found = 1'b1;
            w_low   = IW'(i);
         end
      end
      if (r_op == OP_ADC && r_bcast_left != 2'd0) begin
         w_nkind = K_BCAST;
         w_nsel  = r_mask;
         w_naddr = PORT_MUX;
         w_ndout = r_mux;
         w_ndir  = 1'b1;
         w_nrd   = 1'b0;
      end else if (r_op == OP_ADC && r_adc_lo) begin
         w_nkind = K_LOW;
         w_nsel  = NUM_BOARDS'(1) << r_cur;
         w_naddr = PORT_ADC_LOW;
      end else if (w_found) begin
         w_nsel = NUM_BOARDS'(1) << w_low;
         if (r_op == OP_WRITE) begin
            w_ndout = r_wdata[8*int'(w_low) +: 8];
            w_ndir  = 1'b1;
            w_nrd   = 1'b0;
         end else if (r_op == OP_ADC) begin
            w_naddr = PORT_ADC_HIGH;
         end
      end else begin
         w_have_next = 1'b0;
      end
   end

   always_comb begin
      w_phase_end = (r_cnt == W_LAST);
      w_start     = 1'b0;
      w_to_wait   = 1'b0;
      w_to_done   = 1'b0;
      w_byte      = (r_op == OP_READ) ? {1'b0, r_cur} : {r_cur, ~r_adc_lo};
      case (r_state)
         S_NEXT: begin
            if (r_mask != '0 && w_have_next) w_start = 1'b1;
            else                              w_to_done = 1'b1;
         end
         S_RELEASE: begin
            if (w_phase_end) begin
               if (r_wait_pend && r_bcast_left == 2'd0) w_to_wait = 1'b1;
               else if (w_have_next)                    w_start   = 1'b1;
               else                                     w_to_done = 1'b1;
            end
         end
         S_ADC_WAIT: begin
            if (r_cnt == C_LAST) begin
               if (w_have_next) w_start   = 1'b1;
               else             w_to_done = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_op         <= OP_WRITE;
         r_port       <= '0;
         r_mask       <= '0;
         r_wdata      <= '0;
         r_mux        <= '0;
         r_pending    <= '0;
         r_cur        <= '0;
         r_bcast_left <= '0;
         r_wait_pend  <= 1'b0;
         r_adc_lo     <= 1'b0;
         r_sel        <= '0;
         r_addr       <= '0;
         r_dout       <= '0;
         r_dir        <= 1'b0;
         r_rd         <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_count  <= '0;
         r_rsp_data   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op         <= cmd_op;
                  r_port       <= cmd_port;
                  r_mask       <= cmd_board_mask;
                  r_wdata      <= cmd_wdata;
                  r_mux        <= cmd_mux;
                  r_pending    <= cmd_board_mask;
                  r_bcast_left <= (cmd_op == OP_ADC) ? 2'd2 : 2'd0;
                  r_wait_pend  <= (cmd_op == OP_ADC);
                  r_adc_lo     <= 1'b0;
                  r_rsp_err    <= (cmd_op == OP_RSVD);
                  r_rsp_count  <= '0;
                  r_rsp_data   <= '0;
                  r_state      <= (cmd_op == OP_RSVD) ? S_DONE : S_NEXT;
               end
            end
            S_SETUP, S_STROBE: begin
               r_cnt <= w_phase_end ? '0 : r_cnt + CW'(1);
               if (w_phase_end) r_state <= (r_state == S_SETUP) ? S_STROBE : S_RELEASE;
               if (r_state == S_STROBE && w_phase_end && r_rd) begin
                  r_rsp_data[8*int'(w_byte) +: 8] <= Data_In_Port;
                  r_rsp_count                     <= r_rsp_count + 8'd1;
               end
            end
            S_RELEASE, S_ADC_WAIT: r_cnt <= r_cnt + CW'(1);
            S_DONE:                r_state <= S_IDLE;
            default:               r_state <= S_IDLE;
         endcase

         if (w_start) begin
            r_state <= S_SETUP;
            r_cnt   <= '0;
            r_sel   <= w_nsel;
            r_addr  <= w_naddr;
            r_dout  <= w_ndout;
            r_dir   <= w_ndir;
            r_rd    <= w_nrd;
            if (w_nkind == K_BCAST) begin
               r_bcast_left <= r_bcast_left - 2'd1;
            end else if (w_nkind == K_LOW) begin
               r_adc_lo <= 1'b0;
            end else begin
               r_pending[w_low] <= 1'b0;
               r_cur            <= w_low;
               r_adc_lo         <= (r_op == OP_ADC);
            end
         end
         if (w_to_wait) begin
            r_state     <= S_ADC_WAIT;
            r_cnt       <= '0;
            r_wait_pend <= 1'b0;
         end
         if (w_to_done) r_state <= S_DONE;
      end
   end

   // Strobes are decoded from the state register, so a reset releases them on the same edge.
   assign w_on_bus      = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_RELEASE);
   assign BOARD_X       = w_on_bus ? r_sel : '0;
   assign data_dir      = w_on_bus & r_dir;
   assign AddessPortPin = r_addr;
   assign Data_Out_Port = r_dout;
   assign RdP           = !((r_state == S_STROBE) && r_rd);
   assign WrP           = !((r_state == S_STROBE) && !r_rd);
   assign cmd_ready     = (r_state == S_IDLE);
   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_DONE);
   assign rsp_err       = r_rsp_err;
   assign rsp_count     = r_rsp_count;
   assign rsp_data      = r_rsp_data;

endmodule
